// File: rtl/sequenciador_de_comando_if.sv
// Operand-in and result-out valid/ready channels of the command sequencer.
interface sequenciador_de_comando_if #(
  parameter int W  = 8,
  parameter int RW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_x;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_result;

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/sequenciador_de_comando.sv
// Command sequencer: takes one operand, starts the control block, waits for
// its done pulse (or a timeout) and hands the result downstream.
//
// state | meaning
// IDLE  | ready for a new operand
// ARM   | operand latched, waiting for control block idle (ctl_comecou)
// RUN   | start pulsed, timing the wait for ctl_pronto
// HOLD  | result presented, waiting for downstream acceptance
module sequenciador_de_comando #(
  parameter int W       = 8,
  parameter int RW      = 16,
  parameter int TIMEOUT = 32,
  parameter int TW      = 6,
  parameter int CW      = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  sequenciador_de_comando_if.slave bus_io,
  output logic [W-1:0]            dp_x_o,
  input  logic                    ctl_comecou_i,
  input  logic                    ctl_pronto_i,
  output logic                    ctl_inicio_o,
  input  logic [RW-1:0]           dp_result_i,
  output logic                    erro_o,
  output logic                    busy_o,
  output logic [CW-1:0]           job_count_o
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, HOLD} state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  dp_x_q, dp_x_d;
  logic [RW-1:0] out_result_q, out_result_d;
  logic          out_valid_q, out_valid_d;
  logic          ctl_inicio_q, ctl_inicio_d;
  logic          erro_q, erro_d;
  logic [CW-1:0] job_count_q, job_count_d;
  logic [TW-1:0] timer_q, timer_d;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      dp_x_q       <= '0;
      out_result_q <= '0;
      out_valid_q  <= 1'b0;
      ctl_inicio_q <= 1'b0;
      erro_q       <= 1'b0;
      job_count_q  <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      dp_x_q       <= dp_x_d;
      out_result_q <= out_result_d;
      out_valid_q  <= out_valid_d;
      ctl_inicio_q <= ctl_inicio_d;
      erro_q       <= erro_d;
      job_count_q  <= job_count_d;
      timer_q      <= timer_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dp_x_d       = dp_x_q;
    out_result_d = out_result_q;
    out_valid_d  = out_valid_q;
    ctl_inicio_d = 1'b0;
    erro_d       = erro_q;
    job_count_d  = job_count_q;
    timer_d      = timer_q;

    case (state_q)
      IDLE: begin
        if (bus_io.in_valid) begin
          dp_x_d  = bus_io.in_x;
          erro_d  = 1'b0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (ctl_comecou_i) begin
          ctl_inicio_d = 1'b1;
          timer_d      = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        timer_d = timer_q + 1'b1;
        // A done pulse in the last timed cycle still counts as success.
        if (ctl_pronto_i) begin
          out_result_d = dp_result_i;
          out_valid_d  = 1'b1;
          job_count_d  = job_count_q + 1'b1;
          state_d      = HOLD;
        end else if (timer_q == TIMER_LAST) begin
          erro_d  = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus_io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_io.in_ready   = (state_q == IDLE);
  assign bus_io.out_valid  = out_valid_q;
  assign bus_io.out_result = out_result_q;
  assign dp_x_o            = dp_x_q;
  assign ctl_inicio_o      = ctl_inicio_q;
  assign erro_o            = erro_q;
  assign busy_o            = (state_q != IDLE);
  assign job_count_o       = job_count_q;

endmodule

// File: tb/tb_sequenciador_de_comando.sv
// Directed bench for sequenciador_de_comando: reset, handshakes, latency,
// back-pressure, timeout and job counter wrap.
module tb_sequenciador_de_comando;
  logic        clk_i;
  logic        reset_i;
  logic [7:0]  dp_x_o;
  logic        ctl_comecou_i;
  logic        ctl_pronto_i;
  logic        ctl_inicio_o;
  logic [15:0] dp_result_i;
  logic        erro_o;
  logic        busy_o;
  logic [7:0]  job_count_o;

  int total = 0;
  int bad   = 0;

  sequenciador_de_comando_if #(.W(8), .RW(16)) bus ();

  sequenciador_de_comando #(
    .W(8), .RW(16), .TIMEOUT(32), .TW(6), .CW(8)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .bus_io        (bus),
    .dp_x_o        (dp_x_o),
    .ctl_comecou_i (ctl_comecou_i),
    .ctl_pronto_i  (ctl_pronto_i),
    .ctl_inicio_o  (ctl_inicio_o),
    .dp_result_i   (dp_result_i),
    .erro_o        (erro_o),
    .busy_o        (busy_o),
    .job_count_o   (job_count_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_i       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = 8'h00;
    bus.out_ready = 1'b0;
    ctl_comecou_i = 1'b1;
    ctl_pronto_i  = 1'b0;
    dp_result_i   = 16'h0000;
    tick();
    tick();
    reset_i = 1'b1;

    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_busy",      32'(busy_o), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_erro",      32'(erro_o), 32'd0);
    chk("rst_jobs",      32'(job_count_o), 32'd0);
    chk("rst_inicio",    32'(ctl_inicio_o), 32'd0);
    chk("rst_dp_x",      32'(dp_x_o), 32'd0);

    // basic job: accept, inicio two cycles later, pronto 8 cycles after inicio
    bus.in_valid = 1'b1;
    bus.in_x     = 8'h05;
    tick();
    bus.in_valid = 1'b0;
    chk("acc_busy",     32'(busy_o), 32'd1);
    chk("acc_in_ready", 32'(bus.in_ready), 32'd0);
    chk("acc_dp_x",     32'(dp_x_o), 32'h05);
    chk("acc_inicio",   32'(ctl_inicio_o), 32'd0);
    tick();
    chk("inicio_pulse", 32'(ctl_inicio_o), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("inicio_low", 32'(ctl_inicio_o), 32'd0);
    end
    tick();
    ctl_pronto_i = 1'b1;
    dp_result_i  = 16'h0019;
    tick();
    ctl_pronto_i = 1'b0;
    dp_result_i  = 16'h0000;
    chk("j1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("j1_result",    32'(bus.out_result), 32'h0019);
    chk("j1_jobs",      32'(job_count_o), 32'd1);
    chk("j1_dp_x",      32'(dp_x_o), 32'h05);
    chk("j1_erro",      32'(erro_o), 32'd0);

    // back-pressure in HOLD with a competing operand offered
    bus.in_valid = 1'b1;
    bus.in_x     = 8'hAA;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_valid",    32'(bus.out_valid), 32'd1);
      chk("hold_result",   32'(bus.out_result), 32'h0019);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_dp_x",     32'(dp_x_o), 32'h05);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("rel_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rel_in_ready",  32'(bus.in_ready), 32'd1);

    // stray pronto in IDLE
    ctl_pronto_i = 1'b1;
    dp_result_i  = 16'hDEAD;
    tick();
    ctl_pronto_i = 1'b0;
    chk("stray_valid", 32'(bus.out_valid), 32'd0);
    chk("stray_busy",  32'(busy_o), 32'd0);
    chk("stray_jobs",  32'(job_count_o), 32'd1);

    // comecou held low for 5 cycles after accept
    ctl_comecou_i = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_x      = 8'h33;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("arm_inicio", 32'(ctl_inicio_o), 32'd0);
      chk("arm_busy",   32'(busy_o), 32'd1);
    end
    ctl_comecou_i = 1'b1;
    tick();
    chk("arm_go_inicio", 32'(ctl_inicio_o), 32'd1);
    ctl_pronto_i = 1'b1;
    dp_result_i  = 16'h1234;
    tick();
    ctl_pronto_i = 1'b0;
    chk("j2_result", 32'(bus.out_result), 32'h1234);
    chk("j2_jobs",   32'(job_count_o), 32'd2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // timeout: erro lands exactly TIMEOUT cycles after inicio
    bus.in_valid = 1'b1;
    bus.in_x     = 8'h77;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("to_inicio", 32'(ctl_inicio_o), 32'd1);
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk("to_wait_erro", 32'(erro_o), 32'd0);
      chk("to_wait_busy", 32'(busy_o), 32'd1);
    end
    tick();
    chk("to_erro",      32'(erro_o), 32'd1);
    chk("to_busy",      32'(busy_o), 32'd0);
    chk("to_out_valid", 32'(bus.out_valid), 32'd0);
    chk("to_jobs",      32'(job_count_o), 32'd2);
    chk("to_in_ready",  32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_x     = 8'h42;
    tick();
    bus.in_valid = 1'b0;
    chk("to_clear_erro", 32'(erro_o), 32'd0);
    chk("to_clear_dp_x", 32'(dp_x_o), 32'h42);

    // reset for two cycles in the middle of RUN
    tick();
    chk("mid_inicio", 32'(ctl_inicio_o), 32'd1);
    tick();
    reset_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
    chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_inicio",    32'(ctl_inicio_o), 32'd0);
    chk("mr_erro",      32'(erro_o), 32'd0);
    chk("mr_jobs",      32'(job_count_o), 32'd0);
    chk("mr_in_ready",  32'(bus.in_ready), 32'd1);
    chk("mr_dp_x",      32'(dp_x_o), 32'd0);
    ctl_pronto_i = 1'b1;
    dp_result_i  = 16'hBAD0;
    tick();
    ctl_pronto_i = 1'b0;
    chk("mr_late_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_late_jobs",  32'(job_count_o), 32'd0);

    // 255 quick jobs, then the 256th finishes exactly on the timeout cycle
    for (int j = 0; j < 255; j++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 8'(j);
      tick();
      bus.in_valid = 1'b0;
      tick();
      ctl_pronto_i = 1'b1;
      dp_result_i  = 16'(j * 3);
      tick();
      ctl_pronto_i = 1'b0;
      chk("loop_result", 32'(bus.out_result), 32'(16'(j * 3)));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    chk("loop_jobs_ff", 32'(job_count_o), 32'hFF);

    bus.in_valid = 1'b1;
    bus.in_x     = 8'hC3;
    tick();
    bus.in_valid = 1'b0;
    tick();
    for (int k = 1; k <= 30; k++) tick();
    chk("edge_busy_30", 32'(busy_o), 32'd1);
    tick();
    ctl_pronto_i = 1'b1;
    dp_result_i  = 16'hBEEF;
    tick();
    ctl_pronto_i = 1'b0;
    chk("edge_out_valid", 32'(bus.out_valid), 32'd1);
    chk("edge_result",    32'(bus.out_result), 32'hBEEF);
    chk("edge_erro",      32'(erro_o), 32'd0);
    chk("edge_jobs_wrap", 32'(job_count_o), 32'h00);
    chk("edge_dp_x",      32'(dp_x_o), 32'hC3);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("edge_release", 32'(bus.in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
